logistic_regression_hls_deadlock_report_unit: RTL and testbench

Collects the per-process `dl_detect_out` flags from every `logistic_regression_hls_deadlock_detect_unit` instance and arbitrates one global deadlock investigation. It broadcasts `dl_detect_in` back to all units, injects the `origin` token into one chosen process, and raises `token_clear` when the token returns. It latches a sticky report: the origin process, the loop members and the detection cycle. It sits directly downstream of the detect units and feeds their `dl_detect_in`, `origin` and `token_clear` inputs.

---
 rtl/logistic_regression_hls_deadlock_report_unit.sv | 151 +++++++++++++++
 tb/tb_logistic_regression_hls_deadlock_report_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/logistic_regression_hls_deadlock_report_unit.sv
// Global deadlock arbiter: picks one reporting process, circulates the origin
// token and latches a sticky report. Optional false-alarm timeout: LR_DL_TIMEOUT_EN.
module logistic_regression_hls_deadlock_report_unit #(
  parameter int PROC_NUM  = 4,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 kernel_start,
  input  logic [PROC_NUM-1:0]  dl_in_vec,
  output logic                 dl_detect_out,
  output logic [PROC_NUM-1:0]  origin,
  output logic                 token_clear,
  output logic                 dl_valid,
  output logic [PROC_NUM-1:0]  dl_origin,
  output logic [PROC_NUM-1:0]  dl_members,
  output logic [CNT_WIDTH-1:0] dl_cycle
);

  if (PROC_NUM < 2) begin : g_chk_proc
    $error("PROC_NUM must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_chk_tmo
    $error("TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ORIGIN, S_TRACE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [PROC_NUM-1:0]   sel_q, sel_d;
  logic [PROC_NUM-1:0]   origin_q, origin_d;
  logic [PROC_NUM-1:0]   members_q, members_d;
  logic [PROC_NUM-1:0]   dl_origin_q, dl_origin_d;
  logic                  detect_q, detect_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
  logic [PROC_NUM-1:0]   low_bit;
  logic                  tok_ret;
  logic                  tmo_hit;

  // Two's-complement trick isolates the lowest-numbered reporting process.
  assign low_bit = dl_in_vec & (~dl_in_vec + PROC_NUM'(1));
  assign tok_ret = (state_q == S_TRACE) && (|(dl_in_vec & sel_q));
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef LR_DL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  assign tmo_inc = tmo_q + TW'(1);
  assign tmo_hit = (tmo_inc == TW'(TIMEOUT));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    origin_d    = '0;
    members_d   = members_q;
    dl_origin_d = dl_origin_q;
    detect_d    = detect_q;
    valid_d     = valid_q;
    cyc_d       = cyc_q;
    token_clear = tok_ret;
`ifdef LR_DL_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|dl_in_vec) begin
          state_d   = S_ORIGIN;
          sel_d     = low_bit;
          origin_d  = low_bit;
          members_d = low_bit;
          cyc_d     = cnt_q;
          detect_d  = 1'b1;
        end
      end
      S_ORIGIN: begin
        state_d = S_TRACE;
`ifdef LR_DL_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_TRACE: begin
        members_d = members_q | dl_in_vec;
        if (tok_ret) begin
          // A return in the timeout cycle still counts as a real deadlock.
          state_d     = S_DONE;
          valid_d     = 1'b1;
          dl_origin_d = sel_q;
        end else begin
`ifdef LR_DL_TIMEOUT_EN
          tmo_d = tmo_inc;
`endif
          if (tmo_hit) begin
            state_d   = S_IDLE;
            detect_d  = 1'b0;
            members_d = '0;
            cyc_d     = '0;
            sel_d     = '0;
          end
        end
      end
      S_DONE: begin
        // Held until reset/kernel_start; detect stays high to keep units frozen.
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || kernel_start) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      origin_q    <= '0;
      members_q   <= '0;
      dl_origin_q <= '0;
      detect_q    <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      cyc_q       <= '0;
`ifdef LR_DL_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      origin_q    <= origin_d;
      members_q   <= members_d;
      dl_origin_q <= dl_origin_d;
      detect_q    <= detect_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
`ifdef LR_DL_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign dl_detect_out = detect_q;
  assign origin        = origin_q;
  assign dl_valid      = valid_q;
  assign dl_origin     = dl_origin_q;
  assign dl_members    = members_q;
  assign dl_cycle      = cyc_q;

endmodule

// File: tb/tb_logistic_regression_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: timeline-based reference model, per-cycle
// compare, directed pins plus randomized traffic.
module tb_logistic_regression_hls_deadlock_report_unit;
  localparam int P   = 4;
  localparam int CW  = 32;
  localparam int TMO = 8;

  logic          clock = 1'b0;
  logic          reset, kernel_start;
  logic [P-1:0]  vin;
  logic          dl_detect_out, token_clear, dl_valid;
  logic [P-1:0]  origin, dl_origin, dl_members;
  logic [CW-1:0] dl_cycle;

  logistic_regression_hls_deadlock_report_unit #(
    .PROC_NUM(P), .CNT_WIDTH(CW), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .kernel_start(kernel_start),
    .dl_in_vec(vin), .dl_detect_out(dl_detect_out), .origin(origin),
    .token_clear(token_clear), .dl_valid(dl_valid), .dl_origin(dl_origin),
    .dl_members(dl_members), .dl_cycle(dl_cycle)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: timeline of one investigation, in cycles since start.
  bit           armed = 0;
  int           t = 0;
  bit           busy = 0, done = 0;
  int           det_n = 0;
  logic [P-1:0] m_sel = '0, m_mem = '0;
  logic [CW-1:0] m_cyc = '0;

  function automatic logic [P-1:0] lowest(input logic [P-1:0] v);
    for (int p = 0; p < P; p++) if (v[p]) return P'(1) << p;
    return '0;
  endfunction

  always @(posedge clock) begin
    if (reset || kernel_start) begin
      armed = 1; t = 0; busy = 0; done = 0; det_n = 0;
      m_sel = '0; m_mem = '0; m_cyc = '0;
    end else if (armed) begin
      if (done) begin
      end else if (busy) begin
        if (t >= det_n + 2) begin
          m_mem = m_mem | vin;
          if (|(vin & m_sel)) begin
            done = 1; busy = 0;
          end
`ifdef LR_DL_TIMEOUT_EN
          else if (t == det_n + TMO + 1) begin
            busy = 0; m_mem = '0; m_cyc = '0;
          end
`endif
        end
      end else if (|vin) begin
        busy = 1; det_n = t; m_sel = lowest(vin); m_mem = m_sel; m_cyc = CW'(t);
      end
      t++;
    end
  end

  always begin
    @(negedge clock);
    #2;
    if (armed) begin
      chk("detect",    dl_detect_out, busy || done);
      chk("origin",    origin,        (busy && t == det_n + 1) ? m_sel : '0);
      chk("tok_clear", token_clear,   busy && t >= det_n + 2 && (|(vin & m_sel)));
      chk("valid",     dl_valid,      done);
      chk("dl_origin", dl_origin,     done ? m_sel : '0);
      chk("members",   dl_members,    m_mem);
      chk("dl_cycle",  dl_cycle,      m_cyc);
    end
  end

  task automatic cyc(input logic r, input logic k, input logic [P-1:0] v);
    @(negedge clock);
    reset = r; kernel_start = k; vin = v;
  endtask

  initial begin
    reset = 1'b1; kernel_start = 1'b0; vin = '0;
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 0); #3;
    chk("rst_detect", dl_detect_out, 0); chk("rst_valid", dl_valid, 0);
    chk("rst_cycle", dl_cycle, 0); chk("model_t0", t, 0);
    repeat (9) cyc(0, 0, 0);
    cyc(0, 0, 4'b0110);                           // cycle 10
    cyc(0, 0, 0); #3;                             // cycle 11: ORIGIN
    chk("pin_origin", origin, 4'b0010); chk("pin_detect", dl_detect_out, 1);
    chk("pin_cycle", dl_cycle, 10); chk("model_cycle", m_cyc, 10);
    cyc(0, 0, 4'b0100); #3; chk("pin_tc0", token_clear, 0);
    cyc(0, 0, 4'b1000); #3; chk("pin_tc1", token_clear, 0);
    cyc(0, 0, 4'b0010); #3; chk("pin_tc2", token_clear, 1);
    cyc(0, 0, 0); #3;
    chk("pin_valid", dl_valid, 1); chk("pin_members", dl_members, 4'b1110);
    chk("pin_dlorg", dl_origin, 4'b0010); chk("model_mem", m_mem, 4'b1110);
    repeat (5) cyc(0, 0, P'($urandom));
    #3 chk("done_hold", dl_members, 4'b1110);
    // kernel_start in DONE; counter restarts
    cyc(0, 1, 0);
    cyc(0, 0, 0); #3;
    chk("ks_detect", dl_detect_out, 0); chk("ks_valid", dl_valid, 0);
    chk("ks_members", dl_members, 0); chk("ks_dlorg", dl_origin, 0);
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 4'b1000);                           // cycle 3
    cyc(0, 0, 0); #3; chk("ks_cycle3", dl_cycle, 3); chk("ks_origin", origin, 4'b1000);
    cyc(0, 0, 0);                                 // TRACE
    cyc(0, 1, 4'b1000);                           // kernel_start beats the return
    cyc(0, 0, 0); #3;
    chk("kstr_detect", dl_detect_out, 0); chk("kstr_valid", dl_valid, 0);
    chk("kstr_cycle", dl_cycle, 0);
    cyc(0, 1, 4'b0001);                           // kernel_start with a report in IDLE
    cyc(0, 0, 0); #3;
    chk("ksi_origin", origin, 0); chk("ksi_detect", dl_detect_out, 0);
    // return in the would-be timeout cycle
    cyc(0, 0, 4'b0100);
    cyc(0, 0, 0);
    repeat (7) cyc(0, 0, 0);
    cyc(0, 0, 4'b0100); #3; chk("rt_tc", token_clear, 1);
    cyc(0, 0, 0); #3; chk("rt_valid", dl_valid, 1); chk("rt_dlorg", dl_origin, 4'b0100);
    cyc(0, 1, 0);
`ifdef LR_DL_TIMEOUT_EN
    cyc(0, 0, 4'b0010);                           // detection at N
    cyc(0, 0, 0);
    repeat (8) cyc(0, 0, 0); #3;                  // N+9: last TRACE cycle
    chk("to_detect_hi", dl_detect_out, 1);
    cyc(0, 0, 4'b0001); #3;                       // N+10: IDLE, new report
    chk("to_detect_lo", dl_detect_out, 0); chk("to_members", dl_members, 0);
    chk("to_valid", dl_valid, 0); chk("to_cycle", dl_cycle, 0);
    cyc(0, 0, 0); #3;
    chk("to_origin2", origin, 4'b0001); chk("to_detect2", dl_detect_out, 1);
    cyc(0, 1, 0);
`else
    cyc(0, 0, 4'b0001);
    cyc(0, 0, 0);
    repeat (5000) cyc(0, 0, P'($urandom) & 4'b1110); #3;
    chk("long_detect", dl_detect_out, 1); chk("long_valid", dl_valid, 0);
    cyc(0, 0, 4'b0001); #3; chk("long_tc", token_clear, 1);
    cyc(0, 0, 0); #3;
    chk("long_valid2", dl_valid, 1); chk("long_dlorg", dl_origin, 4'b0001);
    cyc(0, 1, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 5) == 0) ? P'($urandom) : '0);
    end
    cyc(0, 0, 0);
    @(negedge clock); #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
